// File: rtl/wash_seq_pkg.sv
// Shared definitions for the wash-stage sequencer: mode/phase encodings,
// per-mode phase durations, program totals and status-light bit positions.
package wash_seq_pkg;

    typedef enum logic [2:0] {
        MODE_DRY    = 3'd0,
        MODE_SMALL  = 3'd1,
        MODE_MEDIUM = 3'd2,
        MODE_BIG    = 3'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_PAUSE = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam int LT_FILL   = 0;
    localparam int LT_WASH   = 1;
    localparam int LT_RINSE  = 2;
    localparam int LT_SPIN   = 3;
    localparam int LT_PAUSED = 4;
    localparam int LT_DONE   = 5;

    localparam logic [5:0] DUR_FILL         = 6'd3;
    localparam logic [5:0] DUR_WASH_SMALL   = 6'd10;
    localparam logic [5:0] DUR_WASH_MEDIUM  = 6'd20;
    localparam logic [5:0] DUR_WASH_BIG     = 6'd30;
    localparam logic [5:0] DUR_RINSE_SMALL  = 6'd5;
    localparam logic [5:0] DUR_RINSE_MEDIUM = 6'd10;
    localparam logic [5:0] DUR_RINSE_BIG    = 6'd15;
    localparam logic [5:0] DUR_SPIN_DRY     = 6'd10;
    localparam logic [5:0] DUR_SPIN_SMALL   = 6'd5;
    localparam logic [5:0] DUR_SPIN_MEDIUM  = 6'd5;
    localparam logic [5:0] DUR_SPIN_BIG     = 6'd10;

    // Program totals in BCD, ready to load into the display counter
    localparam logic [15:0] TOTAL_DRY    = 16'h0010;
    localparam logic [15:0] TOTAL_SMALL  = 16'h0023;
    localparam logic [15:0] TOTAL_MEDIUM = 16'h0038;
    localparam logic [15:0] TOTAL_BIG    = 16'h0058;

    function automatic logic mode_valid(input logic [2:0] m);
        return m <= 3'd3;
    endfunction

    function automatic state_e first_phase(input logic [2:0] m);
        return (m == MODE_DRY) ? ST_SPIN : ST_FILL;
    endfunction

    function automatic state_e next_phase(input state_e ph);
        case (ph)
            ST_FILL:  return ST_WASH;
            ST_WASH:  return ST_RINSE;
            ST_RINSE: return ST_SPIN;
            default:  return ST_DONE;
        endcase
    endfunction

    function automatic logic [15:0] prog_total(input logic [2:0] m);
        case (m)
            MODE_DRY:    return TOTAL_DRY;
            MODE_SMALL:  return TOTAL_SMALL;
            MODE_MEDIUM: return TOTAL_MEDIUM;
            MODE_BIG:    return TOTAL_BIG;
            default:     return 16'h0000;
        endcase
    endfunction

    function automatic logic [5:0] phase_dur(input logic [2:0] m, input state_e ph);
        logic [5:0] d;
        d = 6'd0;
        case (ph)
            ST_FILL: d = DUR_FILL;
            ST_WASH: begin
                case (m)
                    MODE_SMALL:  d = DUR_WASH_SMALL;
                    MODE_MEDIUM: d = DUR_WASH_MEDIUM;
                    MODE_BIG:    d = DUR_WASH_BIG;
                    default:     d = 6'd0;
                endcase
            end
            ST_RINSE: begin
                case (m)
                    MODE_SMALL:  d = DUR_RINSE_SMALL;
                    MODE_MEDIUM: d = DUR_RINSE_MEDIUM;
                    MODE_BIG:    d = DUR_RINSE_BIG;
                    default:     d = 6'd0;
                endcase
            end
            ST_SPIN: begin
                case (m)
                    MODE_DRY:    d = DUR_SPIN_DRY;
                    MODE_SMALL:  d = DUR_SPIN_SMALL;
                    MODE_MEDIUM: d = DUR_SPIN_MEDIUM;
                    MODE_BIG:    d = DUR_SPIN_BIG;
                    default:     d = 6'd0;
                endcase
            end
            default: d = 6'd0;
        endcase
        return d;
    endfunction

    function automatic logic [7:0] light_of(input state_e s);
        logic [7:0] l;
        l = 8'h00;
        case (s)
            ST_FILL:  l[LT_FILL]  = 1'b1;
            ST_WASH:  l[LT_WASH]  = 1'b1;
            ST_RINSE: l[LT_RINSE] = 1'b1;
            ST_SPIN:  l[LT_SPIN]  = 1'b1;
            ST_DONE:  l[LT_DONE]  = 1'b1;
            default:  l = 8'h00;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/wash_seq_if.sv
// Control/status bundle between the wash sequencer and its neighbours
// (preparation stage, centre button, displays, billing stage).
interface wash_seq_if;
    import wash_seq_pkg::*;

    logic        en;
    logic [2:0]  mode;
    logic        m_pos;
    logic [15:0] remain_bcd;
    logic [7:0]  digit_ena;
    logic [7:0]  st_light;
    logic        busy;
    logic        done;

    modport master (
        output en, mode, m_pos,
        input  remain_bcd, digit_ena, st_light, busy, done
    );

    modport slave (
        input  en, mode, m_pos,
        output remain_bcd, digit_ena, st_light, busy, done
    );

endinterface

// File: rtl/wash_seq_bcd_down4.sv
// Four-digit BCD down-counter with synchronous load and decrement enable;
// decrementing at zero holds at zero.
module wash_seq_bcd_down4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        dec_i,
    output logic [15:0] cnt_o,
    output logic        zero_o
);

    logic [15:0] cnt_q, cnt_d;

    // Borrow ripples up from the units digit; a 0 digit wraps to 9
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign zero_o = (cnt_q == 16'h0000);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_o) begin
            cnt_d = bcd_dec(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wash_seq.sv
// Wash-stage sequencer: runs FILL/WASH/RINSE/SPIN on a one-second tick,
// counts total remaining time in BCD, handles pause/resume and abort.
module wash_seq
    import wash_seq_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic      clk,
    input  logic      rst,
    wash_seq_if.slave bus
);

    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    state_e        saved_q, saved_d;
    state_e        phase_nxt;
    logic [2:0]    mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          en_prev_q;

    logic [7:0]    st_light_q, st_light_d;
    logic          busy_q, busy_d;
    logic          lit_q, lit_d;
    logic          done_q, done_d;

    logic          bcd_load, bcd_dec, bcd_zero;
    logic [15:0]   bcd_val, bcd_cnt;

    logic          start, timed, tick;

    assign timed = state_q inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN};
    assign tick  = timed && (presc_q == PRESC_MAX);
    assign start = bus.en && !en_prev_q && (state_q == ST_IDLE);

    wash_seq_bcd_down4 u_remain (
        .clk        (clk),
        .rst        (rst),
        .load_i     (bcd_load),
        .load_val_i (bcd_val),
        .dec_i      (bcd_dec),
        .cnt_o      (bcd_cnt),
        .zero_o     (bcd_zero)
    );

    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        mode_d    = mode_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        phase_nxt = state_q;
        bcd_load  = 1'b0;
        bcd_val   = 16'h0000;
        bcd_dec   = 1'b0;

        if (!bus.en) begin
            // Abort outranks every other event, including a coincident tick
            state_d  = ST_IDLE;
            saved_d  = ST_IDLE;
            presc_d  = '0;
            cnt_d    = 6'd0;
            bcd_load = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d   = bus.mode;
                        presc_d  = '0;
                        bcd_load = 1'b1;
                        if (mode_valid(bus.mode)) begin
                            state_d = first_phase(bus.mode);
                            cnt_d   = phase_dur(bus.mode, first_phase(bus.mode));
                            bcd_val = prog_total(bus.mode);
                        end else begin
                            state_d = ST_DONE;
                            cnt_d   = 6'd0;
                        end
                    end
                end
                ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        bcd_dec = 1'b1;
                        if (cnt_q == 6'd1) begin
                            phase_nxt = next_phase(state_q);
                            cnt_d     = phase_dur(mode_q, phase_nxt);
                        end else begin
                            cnt_d = cnt_q - 6'd1;
                        end
                    end
                    // An exhausted display counter means the program is over regardless
                    if (bcd_zero) begin
                        phase_nxt = ST_DONE;
                    end
                    if (bus.m_pos && (phase_nxt != ST_DONE)) begin
                        state_d = ST_PAUSE;
                        saved_d = phase_nxt;
                    end else begin
                        state_d = phase_nxt;
                    end
                end
                ST_PAUSE: begin
                    if (bus.m_pos) begin
                        state_d = saved_q;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Status outputs are computed from the next state so they register together with it
    always_comb begin
        st_light_d = (state_d == ST_PAUSE) ? (light_of(saved_d) | 8'(1 << LT_PAUSED))
                                           : light_of(state_d);
        busy_d = (state_d inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN, ST_PAUSE});
        lit_d  = busy_d || (state_d == ST_DONE);
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            saved_q    <= ST_IDLE;
            mode_q     <= 3'd0;
            presc_q    <= '0;
            cnt_q      <= 6'd0;
            // Treat en as already high so a level held through reset never starts a program
            en_prev_q  <= 1'b1;
            st_light_q <= 8'h00;
            busy_q     <= 1'b0;
            lit_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            saved_q    <= saved_d;
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            en_prev_q  <= bus.en;
            st_light_q <= st_light_d;
            busy_q     <= busy_d;
            lit_q      <= lit_d;
            done_q     <= done_d;
        end
    end

    assign bus.remain_bcd = bcd_cnt;
    assign bus.digit_ena  = {4'b0000, {4{lit_q}}};
    assign bus.st_light   = st_light_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
